z80_dma_bus_arbiter: RTL and testbench
======================================

Name: z80_dma_bus_arbiter

Overview:
- Shares the test-bench RAM between the tv80s CPU bus and a secondary DMA/loader requester.
- Requests the bus via busrq_n and waits for busak_n. Once the bus is granted, it muxes the DMA port onto the memory and runs single-beat or burst reads and writes, then hands the bus back.
- Sits between the CPU pins and the 64 KiB memory model. Memory has a synchronous read with 1-cycle latency.

Parameters:
- CNT_W, 16: width of the beat counter.
- HOLD_CYCLES, 64: maximum number of cycles the DMA may hold the bus (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_a  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_mreq_n  in  1  CPU memory request.
- cpu_wr_n  in  1  CPU write strobe.
- cpu_busak_n  in  1  CPU bus acknowledge.
- cpu_busrq_n  out  1  bus request to CPU; registered.
- dma_req  in  1  DMA wants the bus; level signal.
- dma_valid  in  1  beat valid.
- dma_we  in  1  1 = write beat, 0 = read beat.
- dma_addr  in  16  beat address.
- dma_wdata  in  8  beat write data.
- dma_last  in  1  final beat of the burst.
- dma_ready  out  1  beat accepted when dma_valid && dma_ready.
- dma_gnt  out  1  DMA owns the bus; registered.
- dma_rdata  out  8  read data; registered.
- dma_rvalid  out  1  1-cycle pulse when dma_rdata is valid.
- beat_cnt  out  CNT_W  beats accepted in the current grant; clears on entry to GRANT.
- protocol_err  out  1  sticky error flag; clears only on reset.
- mem_a  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  8  memory read data, valid 1 cycle after mem_a.

Behaviour:
- Reset values (asynchronous, reset_n=0): state=IDLE, cpu_busrq_n=1, dma_gnt=0, dma_rvalid=0, dma_rdata=00, beat_cnt=0, protocol_err=0, rd_pend=0.
- FSM states: IDLE, REQ, GRANT, RDWAIT, RELEASE.
- IDLE:
  - dma_req=1 -> REQ.
  - cpu_busrq_n goes low on the same clock edge.
- REQ:
  - cpu_busak_n=0 -> GRANT, and dma_gnt goes to 1.
  - dma_req=0 -> RELEASE (withdraw the request).
  - busak has priority if both happen in the same cycle.
- GRANT:
  - dma_ready = 1.
  - Write beat: mem_we = dma_valid & dma_we, combinational in the accept cycle.
  - Read beat: mem_a = dma_addr; the block captures dma_last internally and goes to RDWAIT.
  - beat_cnt increments on every accepted beat and saturates at all-ones.
  - Accepted beat with dma_last=1 -> RELEASE (a write releases immediately; a read releases after RDWAIT).
  - dma_req=0 with no beat accepted -> RELEASE.
- RDWAIT:
  - dma_ready = 0.
  - On the next edge: dma_rdata <= mem_rdata and dma_rvalid pulses for 1 cycle.
  - Then -> RELEASE if the captured last was set or dma_req=0; otherwise -> GRANT.
  - Read latency: accept at edge N, rvalid high in the cycle after edge N+1.
- RELEASE:
  - cpu_busrq_n=1 and dma_gnt=0, both registered on entry.
  - Wait for cpu_busak_n=1, then -> IDLE.
  - dma_req is ignored until IDLE; a re-request needs one IDLE cycle minimum.
- Mux select = dma_gnt (registered).
  - dma_gnt=1: mem_a=dma_addr, mem_wdata=dma_wdata.
  - dma_gnt=0: mem_a=cpu_a, mem_wdata=cpu_do, mem_we = ~cpu_wr_n & ~cpu_mreq_n.
  - While dma_gnt=1, CPU strobes are ignored.
- cpu_busak_n rising while in GRANT or RDWAIT:
  - Set protocol_err.
  - Drop any pending read (no rvalid).
  - -> RELEASE.
- Reset asserted mid-burst: immediate return to reset values, which releases the bus to the CPU.
- dma_ready=0 in every state other than GRANT.

Optional Feature:
- Macro: DMA_HOLD_LIMIT_EN.
- When defined:
  - A hold counter clears on entry to GRANT and increments each cycle in GRANT or RDWAIT.
  - At HOLD_CYCLES: dma_ready is forced low, any outstanding read completes normally, then -> RELEASE.
  - A 1-cycle pulse is emitted on an extra output, dma_abort.
- When not defined: no hold counter, no dma_abort port, and grant length is unbounded.

Test Plan:
- Reset, then idle with CPU executing DD CB B0 4E at 0000 (IX=EADE, (EA8E)=3B) -> busrq_n stays 1 throughout, mem_we follows CPU strobes only, A=39 and PC=0004 at the end.
- dma_req while the CPU runs; 3 write beats to 4000/4001/4002 with data AA/55/C3, last on the third -> busrq_n low, gnt only after busak_n=0, mem holds AA 55 C3, beat_cnt=3, busrq_n high after the last beat, CPU resumes with correct register state.
- 2-beat read of EA8E (3B) and 0003 (4E) -> rvalid pulses 2 cycles after each accept with rdata 3B then 4E, dma_ready low in each RDWAIT cycle.
- dma_req dropped while in REQ before busak -> RELEASE then IDLE, no mem_we, gnt never set.
- busak_n forced high during GRANT -> protocol_err=1 (sticky), gnt=0, no rvalid for a pending read; then reset_n=0 -> protocol_err=0, busrq_n=1.
- DMA_HOLD_LIMIT_EN with HOLD_CYCLES=8 and an endless write burst -> dma_abort pulses, exactly 8 beats accepted, bus released.

Source files
------------

// File: rtl/z80_dma_bus_arbiter.sv
// z80_dma_bus_arbiter: lends the tv80s bench RAM to a DMA/loader port via busrq/busak.
// Optional macro DMA_HOLD_LIMIT_EN caps a grant at HOLD_CYCLES and adds dma_abort.
module z80_dma_bus_arbiter #(
   parameter int CNT_W       = 16,
   parameter int HOLD_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [15:0]      cpu_a,
   input  logic [7:0]       cpu_do,
   input  logic             cpu_mreq_n,
   input  logic             cpu_wr_n,
   input  logic             cpu_busak_n,
   output logic             cpu_busrq_n,
   input  logic             dma_req,
   input  logic             dma_valid,
   input  logic             dma_we,
   input  logic [15:0]      dma_addr,
   input  logic [7:0]       dma_wdata,
   input  logic             dma_last,
   output logic             dma_ready,
   output logic             dma_gnt,
   output logic [7:0]       dma_rdata,
   output logic             dma_rvalid,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             protocol_err,
`ifdef DMA_HOLD_LIMIT_EN
   output logic             dma_abort,
`endif
   output logic [15:0]      mem_a,
   output logic [7:0]       mem_wdata,
   output logic             mem_we,
   input  logic [7:0]       mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, REQ, GRANT, RDWAIT, RELEASE
   } state_t;

   state_t state;
   logic   rd_pend;
   logic   rd_last;
   logic   hold_hit;
   logic   accept;

`ifdef DMA_HOLD_LIMIT_EN
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   logic [HW-1:0] hold_cnt;

   assign hold_hit = (hold_cnt >= HW'(HOLD_CYCLES));

   // hold counter runs while the DMA owns the bus; abort pulses when it trips
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt  <= '0;
         dma_abort <= 1'b0;
      end else begin
         dma_abort <= 1'b0;
         if (state == REQ && !cpu_busak_n) begin
            hold_cnt <= '0;
         end else if (state == GRANT || state == RDWAIT) begin
            if (!hold_hit)
               hold_cnt <= hold_cnt + 1'b1;
            else if (!cpu_busak_n)
               dma_abort <= 1'b1;
         end
      end
   end
`else
   // no hold limit: a grant lasts as long as the DMA wants it
   assign hold_hit = (HOLD_CYCLES < 0);
`endif

   // a beat is only taken while the CPU still holds busak low
   assign dma_ready = (state == GRANT) & ~cpu_busak_n & ~hold_hit;
   assign accept    = dma_valid & dma_ready;

   // memory port follows the registered grant
   always_comb begin
      mem_a     = cpu_a;
      mem_wdata = cpu_do;
      mem_we    = ~cpu_wr_n & ~cpu_mreq_n;
      if (dma_gnt) begin
         mem_a     = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = accept & dma_we;
      end
   end

   // bus ownership state machine with registered handshake outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cpu_busrq_n  <= 1'b1;
         dma_gnt      <= 1'b0;
         dma_rvalid   <= 1'b0;
         dma_rdata    <= 8'h00;
         beat_cnt     <= '0;
         protocol_err <= 1'b0;
         rd_pend      <= 1'b0;
         rd_last      <= 1'b0;
      end else begin
         dma_rvalid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dma_req) begin
                  state       <= REQ;
                  cpu_busrq_n <= 1'b0;
               end
            end
            REQ: begin
               if (!cpu_busak_n) begin
                  state    <= GRANT;
                  dma_gnt  <= 1'b1;
                  beat_cnt <= '0;
               end else if (!dma_req) begin
                  state       <= RELEASE;
                  cpu_busrq_n <= 1'b1;
               end
            end
            GRANT: begin
               if (cpu_busak_n) begin
                  protocol_err <= 1'b1;
                  state        <= RELEASE;
                  cpu_busrq_n  <= 1'b1;
                  dma_gnt      <= 1'b0;
               end else if (hold_hit) begin
                  state       <= RELEASE;
                  cpu_busrq_n <= 1'b1;
                  dma_gnt     <= 1'b0;
               end else if (accept) begin
                  if (~&beat_cnt)
                     beat_cnt <= beat_cnt + 1'b1;
                  if (!dma_we) begin
                     rd_pend <= 1'b1;
                     rd_last <= dma_last;
                     state   <= RDWAIT;
                  end else if (dma_last) begin
                     state       <= RELEASE;
                     cpu_busrq_n <= 1'b1;
                     dma_gnt     <= 1'b0;
                  end
               end else if (!dma_req) begin
                  state       <= RELEASE;
                  cpu_busrq_n <= 1'b1;
                  dma_gnt     <= 1'b0;
               end
            end
            RDWAIT: begin
               rd_pend <= 1'b0;
               if (cpu_busak_n) begin
                  protocol_err <= 1'b1;
                  state        <= RELEASE;
                  cpu_busrq_n  <= 1'b1;
                  dma_gnt      <= 1'b0;
               end else begin
                  dma_rdata  <= mem_rdata;
                  dma_rvalid <= rd_pend;
                  if (rd_last || !dma_req || hold_hit) begin
                     state       <= RELEASE;
                     cpu_busrq_n <= 1'b1;
                     dma_gnt     <= 1'b0;
                  end else begin
                     state <= GRANT;
                  end
               end
            end
            RELEASE: begin
               if (cpu_busak_n)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z80_dma_bus_arbiter.sv
// tb_z80_dma_bus_arbiter: vector table, hand sequences and random DMA bursts
// against a shadow-memory reference; build with DMA_HOLD_LIMIT_EN for the hold test.
`timescale 1ns/1ps
module tb_z80_dma_bus_arbiter;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [15:0]       cpu_a;
   logic [7:0]        cpu_do;
   logic              cpu_mreq_n;
   logic              cpu_wr_n;
   logic              cpu_busak_n = 1'b1;
   logic              cpu_busrq_n;
   logic              dma_req;
   logic              dma_valid;
   logic              dma_we;
   logic [15:0]       dma_addr;
   logic [7:0]        dma_wdata;
   logic              dma_last;
   logic              dma_ready;
   logic              dma_gnt;
   logic [7:0]        dma_rdata;
   logic              dma_rvalid;
   logic [CNT_W-1:0]  beat_cnt;
   logic              protocol_err;
   logic [15:0]       mem_a;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [7:0]        mem_rdata;
`ifdef DMA_HOLD_LIMIT_EN
   logic              dma_abort;
`endif

   always #5 clk = ~clk;

   z80_dma_bus_arbiter #(.CNT_W(CNT_W), .HOLD_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_a(cpu_a), .cpu_do(cpu_do),
      .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n),
      .cpu_busak_n(cpu_busak_n), .cpu_busrq_n(cpu_busrq_n),
      .dma_req(dma_req), .dma_valid(dma_valid), .dma_we(dma_we),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_last(dma_last),
      .dma_ready(dma_ready), .dma_gnt(dma_gnt),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .beat_cnt(beat_cnt), .protocol_err(protocol_err),
`ifdef DMA_HOLD_LIMIT_EN
      .dma_abort(dma_abort),
`endif
      .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   // 64 KiB RAM, synchronous read
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_we) mem[mem_a] <= mem_wdata;
      mem_rdata <= mem[mem_a];
   end

   // CPU bus-acknowledge responder (delayed echo of busrq, or forced high)
   logic [1:0] ack_sr = 2'b11;
   logic       ack_force = 1'b0;
   always @(posedge clk) begin
      #1;
      if (ack_force) begin
         ack_sr      <= 2'b11;
         cpu_busak_n <= 1'b1;
      end else begin
         ack_sr      <= {ack_sr[0], cpu_busrq_n};
         cpu_busak_n <= ack_sr[1];
      end
   end

   // observed read-data pulses and memory writes
   int         rv_n = 0;
   int         we_n = 0;
   logic [7:0] rv_log [0:1023];
   always @(negedge clk) begin
      if (dma_rvalid && rv_n < 1024) begin
         rv_log[rv_n] <= dma_rdata;
         rv_n <= rv_n + 1;
      end
      if (mem_we) we_n <= we_n + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string name);
      int n = 0;
      while (dma_gnt !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check(name, 32'(dma_gnt), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((dma_gnt || !cpu_busrq_n || !cpu_busak_n) && n < 50) begin
         step();
         n++;
      end
      check("idle reached", 32'(cpu_busak_n & cpu_busrq_n), 32'd1);
      step();
   endtask

   // present one beat and hold it until accepted (bounded)
   task automatic beat(input logic we, input logic [15:0] a,
                       input logic [7:0] d, input logic last,
                       input logic force_ack, output logic ok);
      int n = 0;
      dma_valid = 1'b1;
      dma_we    = we;
      dma_addr  = a;
      dma_wdata = d;
      dma_last  = last;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = dma_ready;
         if (ok && force_ack) ack_force = 1'b1;
         step();
         n++;
      end
      dma_valid = 1'b0;
      dma_last  = 1'b0;
   endtask

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        mreq_n;
      logic        wr_n;
      logic        we;
   } cpu_vec_t;

   cpu_vec_t   tab [8];
   logic [7:0] ref_mem [32];
   logic       ref_ok [32];
   logic [7:0] exp_q [$];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic ok;
      int   n, base_we, base_rv, len, idx, acc, ab;
      logic we;
      logic [7:0] d;

      tab[0] = '{16'h0000, 8'hDD, 1'b0, 1'b0, 1'b1};
      tab[1] = '{16'h0001, 8'hCB, 1'b0, 1'b0, 1'b1};
      tab[2] = '{16'h0002, 8'hB0, 1'b0, 1'b0, 1'b1};
      tab[3] = '{16'h0003, 8'h4E, 1'b0, 1'b0, 1'b1};
      tab[4] = '{16'hEA8E, 8'h3B, 1'b0, 1'b0, 1'b1};
      tab[5] = '{16'h0000, 8'h12, 1'b0, 1'b1, 1'b0};
      tab[6] = '{16'hEA8E, 8'h34, 1'b0, 1'b1, 1'b0};
      tab[7] = '{16'h1234, 8'h56, 1'b1, 1'b0, 1'b0};

      reset_n = 1'b0;
      cpu_a = '0; cpu_do = '0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
      dma_req = 1'b0; dma_valid = 1'b0; dma_we = 1'b0;
      dma_addr = '0; dma_wdata = '0; dma_last = 1'b0;
      for (int i = 0; i < 32; i++) ref_ok[i] = 1'b0;

      step();
      check("rst busrq_n", 32'(cpu_busrq_n), 32'd1);
      check("rst gnt", 32'(dma_gnt), 32'd0);
      check("rst rvalid", 32'(dma_rvalid), 32'd0);
      check("rst rdata", 32'(dma_rdata), 32'h00);
      check("rst beat_cnt", 32'(beat_cnt), 32'd0);
      check("rst err", 32'(protocol_err), 32'd0);
      check("rst ready", 32'(dma_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // idle: CPU owns memory, DMA inputs ignored
      for (int i = 0; i < 8; i++) begin
         cpu_a = tab[i].a; cpu_do = tab[i].d;
         cpu_mreq_n = tab[i].mreq_n; cpu_wr_n = tab[i].wr_n;
         dma_valid = 1'b1; dma_we = 1'b1; dma_addr = ~tab[i].a;
         dma_wdata = ~tab[i].d;
         @(negedge clk);
         check("idle mem_a", 32'(mem_a), 32'(tab[i].a));
         check("idle mem_wdata", 32'(mem_wdata), 32'(tab[i].d));
         check("idle mem_we", 32'(mem_we), 32'(tab[i].we));
         check("idle busrq_n", 32'(cpu_busrq_n), 32'd1);
         check("idle gnt", 32'(dma_gnt), 32'd0);
         step();
      end
      cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1; dma_valid = 1'b0;
      check("cpu wrote EA8E", 32'(mem[16'hEA8E]), 32'h3B);
      check("cpu wrote 0003", 32'(mem[16'h0003]), 32'h4E);

      // 3-beat write burst
      dma_req = 1'b1;
      step();
      check("req busrq_n", 32'(cpu_busrq_n), 32'd0);
      check("req no gnt", 32'(dma_gnt), 32'd0);
      wait_gnt("wr gnt");
      check("gnt after busak", 32'(cpu_busak_n), 32'd0);
      beat(1'b1, 16'h4000, 8'hAA, 1'b0, 1'b0, ok);
      check("wr beat0", 32'(ok), 32'd1);
      beat(1'b1, 16'h4001, 8'h55, 1'b0, 1'b0, ok);
      check("wr beat1", 32'(ok), 32'd1);
      beat(1'b1, 16'h4002, 8'hC3, 1'b1, 1'b0, ok);
      check("wr beat2", 32'(ok), 32'd1);
      dma_req = 1'b0;
      check("wr rel busrq_n", 32'(cpu_busrq_n), 32'd1);
      check("wr rel gnt", 32'(dma_gnt), 32'd0);
      check("wr beat_cnt", 32'(beat_cnt), 32'd3);
      check("mem 4000", 32'(mem[16'h4000]), 32'hAA);
      check("mem 4001", 32'(mem[16'h4001]), 32'h55);
      check("mem 4002", 32'(mem[16'h4002]), 32'hC3);
      wait_idle();

      // 2-beat read burst with CPU strobes active under the grant
      dma_req = 1'b1;
      wait_gnt("rd gnt");
      cpu_a = 16'h0001; cpu_do = 8'h00; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
      base_we = we_n;
      beat(1'b0, 16'hEA8E, 8'h00, 1'b0, 1'b0, ok);
      check("rd beat0", 32'(ok), 32'd1);
      @(negedge clk);
      check("rdwait0 ready", 32'(dma_ready), 32'd0);
      check("rdwait0 rvalid", 32'(dma_rvalid), 32'd0);
      step();
      @(negedge clk);
      check("rd0 rvalid", 32'(dma_rvalid), 32'd1);
      check("rd0 rdata", 32'(dma_rdata), 32'h3B);
      step();
      beat(1'b0, 16'h0003, 8'h00, 1'b1, 1'b0, ok);
      check("rd beat1", 32'(ok), 32'd1);
      cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
      @(negedge clk);
      check("rdwait1 ready", 32'(dma_ready), 32'd0);
      check("rdwait1 rvalid", 32'(dma_rvalid), 32'd0);
      step();
      @(negedge clk);
      check("rd1 rvalid", 32'(dma_rvalid), 32'd1);
      check("rd1 rdata", 32'(dma_rdata), 32'h4E);
      check("rd rel gnt", 32'(dma_gnt), 32'd0);
      check("rd beat_cnt", 32'(beat_cnt), 32'd2);
      step();
      dma_req = 1'b0;
      check("cpu strobes ignored", 32'(we_n - base_we), 32'd0);
      check("mem 0001 kept", 32'(mem[16'h0001]), 32'hCB);
      wait_idle();

      // request withdrawn before busak
      ack_force = 1'b1;
      base_we = we_n;
      dma_req = 1'b1;
      step();
      step();
      check("wd busrq_n low", 32'(cpu_busrq_n), 32'd0);
      dma_req = 1'b0;
      n = 0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dma_gnt) acc++;
         step();
      end
      check("wd busrq_n high", 32'(cpu_busrq_n), 32'd1);
      check("wd never gnt", 32'(acc), 32'd0);
      check("wd no mem_we", 32'(we_n - base_we), 32'd0);
      ack_force = 1'b0;
      wait_idle();

      // busak_n rises under a pending read
      dma_req = 1'b1;
      wait_gnt("pe gnt");
      base_rv = rv_n;
      beat(1'b0, 16'h4000, 8'h00, 1'b0, 1'b1, ok);
      check("pe beat", 32'(ok), 32'd1);
      step();
      @(negedge clk);
      check("pe err", 32'(protocol_err), 32'd1);
      check("pe gnt", 32'(dma_gnt), 32'd0);
      check("pe busrq_n", 32'(cpu_busrq_n), 32'd1);
      dma_req = 1'b0;
      step();
      step();
      step();
      ack_force = 1'b0;
      check("pe no rvalid", 32'(rv_n - base_rv), 32'd0);
      wait_idle();

      // error stays set across a new grant; reset mid-burst clears it
      dma_req = 1'b1;
      wait_gnt("rst gnt");
      check("err sticky", 32'(protocol_err), 32'd1);
      beat(1'b1, 16'h8000, 8'h11, 1'b0, 1'b0, ok);
      check("rst beat", 32'(ok), 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst gnt", 32'(dma_gnt), 32'd0);
      check("midrst busrq_n", 32'(cpu_busrq_n), 32'd1);
      check("midrst err", 32'(protocol_err), 32'd0);
      check("midrst beat_cnt", 32'(beat_cnt), 32'd0);
      dma_req = 1'b0;
      step();
      reset_n = 1'b1;
      wait_idle();

      // random bursts against shadow memory
      base_rv = rv_n;
      for (int b = 0; b < 40; b++) begin
         len = int'($urandom_range(1, 5));
         dma_req = 1'b1;
         wait_gnt("rand gnt");
         for (int i = 0; i < len; i++) begin
            n = int'($urandom_range(0, 2));
            for (int g = 0; g < n; g++) step();
            idx = int'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            if (!ref_ok[idx]) we = 1'b1;
            d = 8'($urandom);
            beat(we, 16'(16'h9000 + idx), d, i == len - 1, 1'b0, ok);
            check("rand beat", 32'(ok), 32'd1);
            if (we) begin
               ref_mem[idx] = d;
               ref_ok[idx]  = 1'b1;
            end else begin
               exp_q.push_back(ref_mem[idx]);
            end
         end
         dma_req = 1'b0;
         n = 0;
         while ((dma_gnt || !cpu_busrq_n) && n < 20) begin
            step();
            n++;
         end
         check("rand released", 32'(cpu_busrq_n), 32'd1);
         check("rand beat_cnt", 32'(beat_cnt), 32'(len));
         wait_idle();
      end
      step();
      check("rand rvalid count", 32'(rv_n - base_rv), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         if (base_rv + k < rv_n)
            check("rand rdata", 32'(rv_log[base_rv + k]), 32'(exp_q[k]));
      for (int i = 0; i < 32; i++)
         if (ref_ok[i])
            check("rand mem", 32'(mem[16'(16'h9000 + i)]), 32'(ref_mem[i]));

`ifdef DMA_HOLD_LIMIT_EN
      // endless write burst is cut off after HOLD_CYCLES beats
      dma_req = 1'b1;
      wait_gnt("hold gnt");
      dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'hA000;
      dma_wdata = 8'h5A; dma_last = 1'b0;
      acc = 0;
      ab = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (dma_ready && dma_valid) acc++;
         if (dma_abort) ab++;
         step();
      end
      dma_valid = 1'b0;
      check("hold beats", 32'(acc), 32'd8);
      check("hold abort", 32'(ab), 32'd1);
      check("hold beat_cnt", 32'(beat_cnt), 32'd8);
      check("hold gnt", 32'(dma_gnt), 32'd0);
      dma_req = 1'b0;
      wait_idle();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
